// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes, status
// flags, operand isolation and an idle counter that raises a sleep request.
//
// Ports:
//   clk          single clock, all state changes on its rising edge
//   clear        synchronous active-high reset
//   in_valid     operand/opcode transfer valid
//   in_ready     ALU can accept a transfer this cycle
//   in_a, in_b   operands (shift amount is in_b[log2(WIDTH)-1:0])
//   in_op        4-bit opcode
//   out_valid    result valid
//   out_ready    downstream accepts the result
//   out_result   result
//   out_zero     result is zero
//   out_negative result MSB
//   out_carry    ADD carry-out / SUB borrow, else 0
//   out_overflow ADD/SUB signed overflow, else 0
//   out_err      illegal opcode (1100..1111)
//   sleep        idle limit reached
module alu_pipe #(
  parameter int WIDTH      = 32,
  parameter int IDLE_LIMIT = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_negative,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_err,
  output logic             sleep
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [7:0] LIMIT = 8'(IDLE_LIMIT);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_MIN  = 4'b1010;
  localparam logic [3:0] OP_MAX  = 4'b1011;

  // Stage 1: operand registers
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [3:0]       r_s1_op;

  // Stage 2: result and flag registers
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_negative;
  logic             r_carry;
  logic             r_overflow;
  logic             r_err;

  logic [7:0]       r_idle_cnt;

  logic             w_advance;
  logic             w_accept;
  logic             w_idle;

  // Stage 2 can take new data when it is empty or is being drained now.
  assign w_advance = !r_s2_valid | out_ready;
  assign in_ready  = !clear & (!r_s1_valid | w_advance);
  assign w_accept  = in_valid & in_ready;
  assign w_idle    = !in_valid & !r_s1_valid & !r_s2_valid;

  // ---------------------------------------------------------------------
  // Combinational ALU on the stage-1 registers
  // ---------------------------------------------------------------------
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_sra;
  logic             w_ltu;
  logic             w_lts;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  logic             w_err;

  assign w_sum   = {1'b0, r_s1_a} + {1'b0, r_s1_b};
  assign w_diff  = {1'b0, r_s1_a} - {1'b0, r_s1_b};
  assign w_shamt = r_s1_b[SHW-1:0];
  assign w_sra   = $signed(r_s1_a) >>> w_shamt;
  assign w_ltu   = r_s1_a < r_s1_b;
  assign w_lts   = $signed(r_s1_a) < $signed(r_s1_b);

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_err   = 1'b0;
    case (r_s1_op)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) &&
                  (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = w_diff[WIDTH-1:0];
        // The extra bit of an unsigned (WIDTH+1)-bit difference is the borrow.
        w_carry = w_diff[WIDTH];
        w_ovf   = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) &&
                  (w_diff[WIDTH-1] != r_s1_a[WIDTH-1]);
      end
      OP_AND:  w_res = r_s1_a & r_s1_b;
      OP_OR:   w_res = r_s1_a | r_s1_b;
      OP_XOR:  w_res = r_s1_a ^ r_s1_b;
      OP_SLL:  w_res = r_s1_a << w_shamt;
      OP_SRL:  w_res = r_s1_a >> w_shamt;
      OP_SRA:  w_res = w_sra;
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, w_ltu};
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_lts};
      OP_MIN:  w_res = w_lts ? r_s1_a : r_s1_b;
      OP_MAX:  w_res = w_lts ? r_s1_b : r_s1_a;
      default: w_err = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // Stage 1: operands change only on an accepted transfer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clear) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_a     <= in_a;
      r_s1_b     <= in_b;
      r_s1_op    <= in_op;
    end else if (w_advance) begin
      r_s1_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: result and flags; hold stable while stalled
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clear) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_err      <= 1'b0;
    end else if (r_s1_valid && w_advance) begin
      r_s2_valid <= 1'b1;
      r_result   <= w_res;
      r_zero     <= (w_res == '0);
      r_negative <= w_res[WIDTH-1];
      r_carry    <= w_carry;
      r_overflow <= w_ovf;
      r_err      <= w_err;
    end else if (w_advance) begin
      r_s2_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Idle counter, saturating at the limit
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clear) begin
      r_idle_cnt <= '0;
    end else if (!w_idle) begin
      r_idle_cnt <= '0;
    end else if (r_idle_cnt < LIMIT) begin
      r_idle_cnt <= r_idle_cnt + 8'd1;
    end
  end

  assign sleep        = (r_idle_cnt == LIMIT);
  assign out_valid    = r_s2_valid;
  assign out_result   = r_result;
  assign out_zero     = r_zero;
  assign out_negative = r_negative;
  assign out_carry    = r_carry;
  assign out_overflow = r_overflow;
  assign out_err      = r_err;

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the single-register low-power ALU.
- Adds a valid/ready handshake on input and output, and arithmetic status flags.
- Adds operand isolation: operand registers load only on an accepted transfer.
- Adds an idle counter that raises a sleep indication for the system power controller.
- Sits between the issue logic and writeback; the same opcode encoding is kept and extended.

Parameters:
WIDTH, 32, datapath width in bits; must be a power of two, range 8 to 64.
IDLE_LIMIT, 16, consecutive idle cycles before sleep asserts; range 1 to 255.

Ports:
clk  input  1  single clock; all state updates on its rising edge
clear  input  1  synchronous active-high reset
in_valid  input  1  operand/opcode transfer valid
in_ready  output  1  ALU can accept a transfer this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B; shift amount is in_b[log2(WIDTH)-1:0]
in_op  input  4  opcode
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
out_result  output  WIDTH  result
out_zero  output  1  out_result == 0
out_negative  output  1  out_result[WIDTH-1]
out_carry  output  1  ADD: carry-out; SUB: borrow (A < B unsigned); 0 for all other opcodes
out_overflow  output  1  signed overflow for ADD/SUB; 0 for all other opcodes
out_err  output  1  opcode was illegal (1100 to 1111)
sleep  output  1  idle-limit reached

Behaviour:
- Interface rule: one clock `clk`; reset `clear` is synchronous and active-high.
- Reset (clear sampled high at a clk edge):
  - s1_valid = 0, s2_valid = 0, idle counter = 0, sleep = 0.
  - out_valid = 0, out_result = 0, all flags = 0.
  - in_ready = 0 while clear is high; in_ready = 1 the first cycle after clear deasserts.
  - Reset in the middle of operation discards all in-flight transfers; no partial result appears on the output.
- Opcodes:
  - 0000 ADD, 0001 SUB (A-B), 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA.
  - 1000 SLTU, 1001 SLT: result {0..0, bit}.
  - 1010 MIN signed, 1011 MAX signed.
  - 1100 to 1111: result 0, out_err = 1.
- Arithmetic: ADD/SUB are computed at WIDTH+1 bits for carry/borrow.
  - Overflow for ADD: sign(A) == sign(B) and sign(result) != sign(A).
  - Overflow for SUB: sign(A) != sign(B) and sign(result) != sign(A).
  - Results wrap modulo 2^WIDTH.
- Stage 1 (operand register):
  - Loads in_a, in_b, in_op only when in_valid & in_ready; otherwise holds. This is the isolation rule: no toggling without an accepted transfer.
  - s1_valid is set on accept and cleared when the stage-1 contents advance with no new accept.
- Stage 2 (result register):
  - Computes from the stage-1 registers and loads result and flags when s1_valid & advance.
  - advance = !s2_valid | out_ready.
- Handshake:
  - in_ready = !clear & (!s1_valid | advance).
  - An output transfer occurs when out_valid & out_ready; out_valid = s2_valid.
  - While out_valid & !out_ready, out_result and all flags hold stable.
  - in_valid may assert without waiting for in_ready. in_a, in_b and in_op need only be valid when in_valid is high.
- Latency and throughput:
  - Accept at edge N gives out_valid high after edge N+1.
  - Throughput is one result per cycle with out_ready held high.
  - A full pipeline under backpressure holds 2 entries; in_ready drops only when both stages are full and out_ready = 0.
- Simultaneous events: in the same cycle, stage 2 drains, stage 1 advances and a new accept lands; no bubble and no loss.
- Idle counter:
  - Increments each cycle in which !in_valid & !s1_valid & !s2_valid, saturating at IDLE_LIMIT.
  - sleep = (count == IDLE_LIMIT).
  - Any in_valid, or a non-empty pipeline, resets the count to 0 and sleep to 0 at the next edge.
  - in_ready is unaffected by sleep: an accept while sleeping is processed normally.
- Flags: out_zero and out_negative derive from the registered result. out_carry and out_overflow are registered with it.

Test Plan:
- Reset then ADD: A=0xFFFFFFFF, B=0x00000001 -> 2 cycles later:
  - result 0x00000000, zero=1, carry=1, overflow=0.
- SUB overflow: A=0x80000000, B=0x00000001 -> result 0x7FFFFFFF, overflow=1, carry=0, negative=0.
- Shifts: SRA A=0xF0000000, B=0x00000024 -> shift amount 4 taken from the low 5 bits, result 0xFF000000, negative=1.
- Shifts: SLL A=1, B=31 -> result 0x80000000.
- Backpressure: stream 4 ADDs with out_ready=0:
  - in_ready falls after 2 accepts and the first result holds stable.
  - Releasing out_ready gives all 4 results, in order, on consecutive cycles.
- MIN/MAX and illegal opcode:
  - MIN A=0xFFFFFFFE, B=3 -> 0xFFFFFFFE.
  - MAX on the same operands -> 3.
  - op=1101 -> result 0, err=1, zero=1.
- Idle/sleep and clear: with IDLE_LIMIT=4, idle 4 cycles -> sleep=1.
  - in_valid wakes: sleep=0 at the next edge and the result is correct.
  - clear asserted with 2 entries in flight -> out_valid=0 at the next edge; no stale result is ever output.
